seg_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_bcd_dec.sv | 25 ++
 rtl/seg_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and segment patterns for the 7-segment scan controller.
// Patterns are {a,b,c,d,e,f,g}, active-high.
package seg_pkg;

    typedef enum logic {
        ST_ON    = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

endpackage

// File: rtl/seg_bcd_dec.sv
// Combinational BCD to 7-segment decoder; non-BCD codes (10..15) go dark
// rather than showing a partial glyph.
module seg_bcd_dec (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    import seg_pkg::*;

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed NDIG-digit 7-segment scan controller with frame-aligned
// value updates. Define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DWELL = 1000,
    parameter int BLANK = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [4*NDIG-1:0] in_data,
    output logic              in_ready,
    output logic [NDIG-1:0]   an,
    output logic [3:0]        digit_bcd,
    output logic [6:0]        seg,
    output logic              frame_done
);
    import seg_pkg::*;

    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int IW   = $clog2(NDIG);

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d, idx_nxt;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic [3:0]        digit_bcd_q, digit_bcd_d;
    logic [4*NDIG-1:0] disp_q, disp_d;
    logic [4*NDIG-1:0] pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic              frame_done_q, frame_done_d;
    logic              wrap;
    logic              lit;
    logic [3:0]        nib;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        an_d         = an_q;
        digit_bcd_d  = digit_bcd_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        frame_done_d = 1'b0;
        wrap         = (idx_q == IW'(NDIG - 1));
        idx_nxt      = wrap ? '0 : idx_q + 1'b1;
        nib          = '0;
        lit          = 1'b1;

        case (state_q)
            ST_ON: begin
                if (cnt_q == '0) begin
                    state_d = ST_BLANK;
                    cnt_d   = CW'(BLANK - 1);
                    an_d    = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = ST_ON;
                    cnt_d   = CW'(DWELL - 1);
                    idx_d   = idx_nxt;
                    // Swap uses the registered pend_full, so a value accepted on
                    // this very edge waits for the following boundary.
                    if (wrap) begin
                        frame_done_d = 1'b1;
                        if (pend_full_q) begin
                            disp_d      = pend_q;
                            pend_full_d = 1'b0;
                        end
                    end
                    for (int k = 0; k < NDIG; k++) begin
                        if (IW'(k) == idx_nxt) nib = disp_d[4*k +: 4];
                    end
`ifdef SEG_LZB_EN
                    lit = (idx_nxt == '0);
                    for (int k = 0; k < NDIG; k++) begin
                        if (IW'(k) >= idx_nxt && disp_d[4*k +: 4] != 4'd0) lit = 1'b1;
                    end
`endif
                    digit_bcd_d = nib;
                    an_d        = lit ? (NDIG'(1) << idx_nxt) : '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase

        if (in_valid && !pend_full_q) begin
            pend_d      = in_data;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            idx_q        <= IW'(NDIG - 1);
            cnt_q        <= CW'(BLANK - 1);
            an_q         <= '0;
            digit_bcd_q  <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            an_q         <= an_d;
            digit_bcd_q  <= digit_bcd_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            frame_done_q <= frame_done_d;
        end
    end

    seg_bcd_dec u_dec (
        .bcd (digit_bcd_q),
        .seg (seg)
    );

    assign in_ready   = !pend_full_q;
    assign an         = an_q;
    assign digit_bcd  = digit_bcd_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NDIG=4, DWELL=4, BLANK=2); honours
// SEG_LZB_EN for the expected digit enables.
module tb_seg_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = DWELL + BLANK;
    localparam int FRAME = NDIG * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic [3:0]  an;
    logic [3:0]  digit_bcd;
    logic [6:0]  seg;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .an         (an),
        .digit_bcd  (digit_bcd),
        .seg        (seg),
        .frame_done (frame_done)
    );

    int n_chk = 0;
    int n_err = 0;
    int t;

    // Edges since reset release; boundary of frame f lands on edge BLANK+f*FRAME.
    always @(posedge clk or posedge rst) begin
        if (rst) t <= 0;
        else     t <= t + 1;
    end

    typedef struct {
        int          frame;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d: got %0h want %0h", tag, t, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic ref_lit(input logic [15:0] v, input int s);
        logic r;
        r = (s == 0) || ((v >> (4 * s)) != 16'd0);
`ifndef SEG_LZB_EN
        r = 1'b1;
`endif
        return r;
    endfunction

    // Monitor: every cycle compare outputs against the frame/slot position
    // and the value the scoreboard says is on display.
    logic [15:0] cur = '0;
    exp_t        e_mon;
    initial begin
        int p, f, s, q;
        logic [3:0] nb, ea;
        forever begin
            @(negedge clk);
            if (rst) begin
                cur = '0;
                chk("rst_an", an, 0);
                chk("rst_bcd", digit_bcd, 0);
                chk("rst_fd", frame_done, 0);
                chk("rst_ready", in_ready, 1);
            end else if (t < BLANK) begin
                chk("pre_an", an, 0);
                chk("pre_bcd", digit_bcd, 0);
                chk("pre_fd", frame_done, 0);
            end else begin
                p = (t - BLANK) % FRAME;
                f = (t - BLANK) / FRAME;
                if (p == 0 && sb.size() > 0 && sb[0].frame == f) begin
                    e_mon = sb.pop_front();
                    cur   = e_mon.val;
                end
                s  = p / SLOT;
                q  = p % SLOT;
                nb = cur[4*s +: 4];
                ea = (q < DWELL && ref_lit(cur, s)) ? 4'(1 << s) : 4'd0;
                chk("an", an, ea);
                chk("digit_bcd", digit_bcd, nb);
                chk("seg", seg, ref_seg(nb));
                chk("frame_done", frame_done, (p == 0));
            end
        end
    end

    task automatic goto_t(input int n);
        int guard = 0;
        while (t < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("goto", t, n);
    endtask

    // Offer v for one edge; on acceptance the value is due at the first
    // boundary strictly after the accepting edge.
    task automatic send(input logic [15:0] v, input logic acc);
        int ta;
        chk("ready_pre", in_ready, acc);
        in_valid = 1'b1;
        in_data  = v;
        ta       = t + 1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        if (acc) begin
            sb.push_back('{(ta - BLANK) / FRAME + 1, v});
            chk("ready_post", in_ready, 0);
        end
    endtask

    initial begin
        sb.push_back('{0, 16'h0000});
        repeat (3) @(negedge clk);
        rst = 1'b0;

        goto_t(9);   send(16'h1234, 1'b1);
        goto_t(13);  send(16'h9999, 1'b0);
        goto_t(25);  chk("ready_hold", in_ready, 0);
        goto_t(26);  chk("ready_back", in_ready, 1);
        goto_t(49);  send(16'h0005, 1'b1);
        goto_t(79);  send(16'h00AB, 1'b1);
        goto_t(103); send(16'h0070, 1'b1);
        goto_t(151); send(16'h5555, 1'b1);

        // Mid-frame reset: outputs clear at once and the pending 0x5555 is dropped.
        goto_t(160);
        #3 rst = 1'b1;
        #1;
        chk("async_an", an, 0);
        chk("async_bcd", digit_bcd, 0);
        chk("async_fd", frame_done, 0);
        chk("async_ready", in_ready, 1);
        sb.delete();
        sb.push_back('{0, 16'h0000});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        goto_t(80);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
